ram_ctrl: RTL and testbench

- Parametrised on-chip SRAM slave for the peripheral block's req/gnt/rvalid bus.
- Successor to the fixed 32 KiB RAM, adding:
  - configurable base address, decode window, depth and read latency
  - one grant per cycle (back-to-back accesses)
  - error response for holes in the window
  - hardware zero-initialisation after reset
- Sits on the peripheral bus beside the other slaves; one instance per memory region.

---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_ctrl_if.sv | 25 ++
 rtl/ram_array.sv | 46 ++++
 rtl/ram_ctrl.sv | 149 ++++++++++++++
 tb/tb_ram_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types for the parametrised SRAM slave (ram_ctrl).
// Optional parity storage is enabled by defining RAM_PARITY_EN.
package ram_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    localparam int MAX_READ_LATENCY = 2;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// req/gnt/rvalid peripheral bus bundle for the SRAM slave.
// Signal set is identical with or without RAM_PARITY_EN.
interface ram_ctrl_if;

    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/ram_array.sv
// Single-port DEPTH x 32 storage with per-byte write enables.
// RAM_PARITY_EN adds one even-parity bit per byte lane.
module ram_array
    import ram_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          wr,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
`ifdef RAM_PARITY_EN
    output logic [3:0]    rpar,
`endif
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH];
`ifdef RAM_PARITY_EN
    logic [3:0]      par_mem [DEPTH];
`endif

    always_ff @(posedge clk) begin
        if (en) begin
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[idx][i] <= wdata[8*i +: 8];
`ifdef RAM_PARITY_EN
                        par_mem[idx][i] <= byte_par(wdata[8*i +: 8]);
`endif
                    end
                end
            end else begin
                rdata <= mem[idx];
`ifdef RAM_PARITY_EN
                rpar  <= par_mem[idx];
`endif
            end
        end
    end

endmodule

// File: rtl/ram_ctrl.sv
// Parametrised on-chip SRAM slave with zero-init, hole errors and 1/2-cycle reads.
// Define RAM_PARITY_EN to store and check per-byte even parity.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int          WINDOW_BITS  = 16,
    parameter int          DEPTH        = 8192,
    parameter int          READ_LATENCY = 1
) (
    input  logic      clk,
    input  logic      rst,
    ram_ctrl_if.slave bus,
    output logic      init_done
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] WIN_MASK = (32'd1 << WINDOW_BITS) - 32'd1;
    localparam logic [31:0] DEPTH_W  = DEPTH;

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [31:0]   off;
    logic          decode, hit, gnt;

    logic          a_en, a_wr;
    logic [3:0]    a_be;
    logic [AW-1:0] a_idx;
    logic [31:0]   a_wdata, a_q;
`ifdef RAM_PARITY_EN
    logic [3:0]    a_par;
`endif

    logic          v1, rd1, err1;
    rsp_t          rsp1;

    always_comb begin
        off    = (bus.addr & WIN_MASK) >> 2;
        decode = (bus.addr & ~WIN_MASK) == (BASE_ADDR & ~WIN_MASK);
        hit    = decode && (off < DEPTH_W);
        gnt    = rst && bus.req && decode && (state == RUN);
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        a_en     = 1'b0;
        a_wr     = 1'b0;
        a_be     = 4'h0;
        a_idx    = bus.addr[AW+1:2];
        a_wdata  = bus.wdata;
        unique case (state)
            INIT: begin
                a_en    = 1'b1;
                a_wr    = 1'b1;
                a_be    = 4'hf;
                a_idx   = cnt;
                a_wdata = '0;
                cnt_nx  = cnt + 1'b1;
                if (cnt == AW'(DEPTH - 1))
                    state_nx = RUN;
            end
            RUN: begin
                a_en = gnt && hit;
                a_wr = bus.we;
                a_be = bus.be;
            end
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign init_done = (state == RUN);
    assign bus.gnt   = gnt;

    ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (a_en),
        .wr    (a_wr),
        .be    (a_be),
        .idx   (a_idx),
        .wdata (a_wdata),
`ifdef RAM_PARITY_EN
        .rpar  (a_par),
`endif
        .rdata (a_q)
    );

    // Flags only move on a grant so the response holds while idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1   <= 1'b0;
            rd1  <= 1'b0;
            err1 <= 1'b0;
        end else begin
            v1 <= gnt;
            if (gnt) begin
                rd1  <= hit && !bus.we;
                err1 <= !hit;
            end
        end
    end

    always_comb begin
        rsp1.rdata = rd1 ? a_q : '0;
        rsp1.err   = err1;
`ifdef RAM_PARITY_EN
        for (int i = 0; i < 4; i++) begin
            if (rd1 && (byte_par(a_q[8*i +: 8]) != a_par[i]))
                rsp1.err = 1'b1;
        end
`endif
    end

    if (READ_LATENCY >= MAX_READ_LATENCY) begin : g_lat2
        logic v2;
        rsp_t rsp2;
        always_ff @(posedge clk) begin
            if (!rst) begin
                v2   <= 1'b0;
                rsp2 <= '0;
            end else begin
                v2 <= v1;
                if (v1)
                    rsp2 <= rsp1;
            end
        end
        assign bus.rvalid = v2;
        assign bus.rdata  = rsp2.rdata;
        assign bus.err    = rsp2.err;
    end else begin : g_lat1
        assign bus.rvalid = v1;
        assign bus.rdata  = rsp1.rdata;
        assign bus.err    = rsp1.err;
    end

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: two instances (read latency 1 and 2) share stimulus.
// Parity backdoor checks are compiled only with RAM_PARITY_EN.
module tb_ram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic done1, done2;

    always #5 clk = ~clk;

    ram_ctrl_if b1 ();
    ram_ctrl_if b2 ();

    ram_ctrl #(
        .BASE_ADDR    (32'h0001_0000),
        .WINDOW_BITS  (16),
        .DEPTH        (16),
        .READ_LATENCY (1)
    ) dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b1),
        .init_done (done1)
    );

    ram_ctrl #(
        .BASE_ADDR    (32'h0001_0000),
        .WINDOW_BITS  (16),
        .DEPTH        (16),
        .READ_LATENCY (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (b2),
        .init_done (done2)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        gnt;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tv [16];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic w,
                         input logic [3:0] e, input logic [31:0] d);
        b1.req = r; b1.addr = a; b1.we = w; b1.be = e; b1.wdata = d;
        b2.req = r; b2.addr = a; b2.we = w; b2.be = e; b2.wdata = d;
    endtask

    // Entered and left at posedge+1; one request, then both response slots.
    task automatic access(input logic w, input logic [31:0] a,
                          input logic [3:0] e, input logic [31:0] d,
                          input logic eg, input logic [31:0] er,
                          input logic ee, input string nm);
        drive(1'b1, a, w, e, d);
        @(negedge clk);
        check($sformatf("%s gnt1", nm), b1.gnt, eg);
        check($sformatf("%s gnt2", nm), b2.gnt, eg);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check($sformatf("%s rvalid1", nm), b1.rvalid, eg);
        check($sformatf("%s rvalid2 early", nm), b2.rvalid, 1'b0);
        if (eg) begin
            check($sformatf("%s rdata1", nm), b1.rdata, er);
            check($sformatf("%s err1", nm), b1.err, ee);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("%s rvalid2", nm), b2.rvalid, eg);
        check($sformatf("%s rvalid1 late", nm), b1.rvalid, 1'b0);
        if (eg) begin
            check($sformatf("%s rdata2", nm), b2.rdata, er);
            check($sformatf("%s err2", nm), b2.err, ee);
        end
        @(posedge clk); #1;
    endtask

    // Entered at posedge+1 with rst low; releases reset and walks INIT.
    task automatic init_seq(input string nm);
        logic bad_g;
        logic early;
        bad_g = 1'b0;
        early = 1'b0;
        rst = 1'b1;
        drive(1'b1, 32'h0001_0000, 1'b0, 4'h0, 32'h0);
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            if (n == 16)
                drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            @(negedge clk);
            if (n < 16) begin
                if (b1.gnt || b2.gnt) bad_g = 1'b1;
                if (done1 || done2) early = 1'b1;
            end else begin
                check($sformatf("%s init_done1", nm), done1, 1'b1);
                check($sformatf("%s init_done2", nm), done2, 1'b1);
            end
        end
        check($sformatf("%s gnt during init", nm), bad_g, 1'b0);
        check($sformatf("%s init_done early", nm), early, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, r1, r2;
        logic [31:0] bd [4];

        tv[0]  = '{1'b0, 32'h0001_0004, 4'h0,    32'h0,         1'b1, 32'h0,         1'b0};
        tv[1]  = '{1'b1, 32'h0001_0004, 4'b0101, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b0};
        tv[2]  = '{1'b0, 32'h0001_0004, 4'h0,    32'h0,         1'b1, 32'h00AD_00EF, 1'b0};
        tv[3]  = '{1'b1, 32'h0001_0000, 4'hf,    32'h1234_5678, 1'b1, 32'h0,         1'b0};
        tv[4]  = '{1'b1, 32'h0001_0000, 4'h0,    32'hAABB_CCDD, 1'b1, 32'h0,         1'b0};
        tv[5]  = '{1'b0, 32'h0001_0000, 4'h0,    32'h0,         1'b1, 32'h1234_5678, 1'b0};
        tv[6]  = '{1'b0, 32'h0001_0040, 4'h0,    32'h0,         1'b1, 32'h0,         1'b1};
        tv[7]  = '{1'b1, 32'h0001_0100, 4'hf,    32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1};
        tv[8]  = '{1'b0, 32'h0001_0000, 4'h0,    32'h0,         1'b1, 32'h1234_5678, 1'b0};
        tv[9]  = '{1'b0, 32'h0002_0000, 4'h0,    32'h0,         1'b0, 32'h0,         1'b0};
        tv[10] = '{1'b1, 32'h0002_0004, 4'hf,    32'h5555_5555, 1'b0, 32'h0,         1'b0};
        tv[11] = '{1'b0, 32'h0001_0004, 4'h0,    32'h0,         1'b1, 32'h00AD_00EF, 1'b0};
        tv[12] = '{1'b1, 32'h0001_003C, 4'hf,    32'h0BAD_F00D, 1'b1, 32'h0,         1'b0};
        tv[13] = '{1'b0, 32'h0001_003F, 4'h0,    32'h0,         1'b1, 32'h0BAD_F00D, 1'b0};
        tv[14] = '{1'b1, 32'h0001_FFFC, 4'hf,    32'h0000_0001, 1'b1, 32'h0,         1'b1};
        tv[15] = '{1'b0, 32'h0001_003C, 4'h0,    32'h0,         1'b1, 32'h0BAD_F00D, 1'b0};

        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset gnt", b1.gnt, 1'b0);
        check("reset rvalid1", b1.rvalid, 1'b0);
        check("reset rvalid2", b2.rvalid, 1'b0);
        check("reset rdata1", b1.rdata, 32'h0);
        check("reset rdata2", b2.rdata, 32'h0);
        check("reset err1", b1.err, 1'b0);
        check("reset err2", b2.err, 1'b0);
        check("reset init_done", done1, 1'b0);
        @(posedge clk); #1;

        init_seq("boot");

        for (int i = 0; i < 16; i++)
            access(1'b0, 32'h0001_0000 + 32'(4 * i), 4'h0, 32'h0,
                   1'b1, 32'h0, 1'b0, $sformatf("zero[%0d]", i));

        for (int i = 0; i < 16; i++)
            access(tv[i].we, tv[i].addr, tv[i].be, tv[i].wdata,
                   tv[i].gnt, tv[i].rdata, tv[i].err, $sformatf("vec[%0d]", i));

        // Back-to-back: write word j then read it on the very next grant.
        for (int j = 0; j < 4; j++)
            bd[j] = 32'hC0DE_0000 | 32'(j * 17);
        g = 0; r1 = 0; r2 = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8)
                drive(1'b1, 32'h0001_0020 + 32'(4 * (k / 2)), (k % 2) == 0,
                      4'hf, bd[k / 2]);
            else
                drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            @(negedge clk);
            if (b1.gnt) g++;
            if (b1.rvalid) begin
                r1++;
                if (k >= 1 && ((k - 1) % 2) == 1)
                    check($sformatf("b2b rdata1 op%0d", k - 1), b1.rdata, bd[(k - 1) / 2]);
            end
            if (b2.rvalid) begin
                r2++;
                if (k >= 2 && ((k - 2) % 2) == 1)
                    check($sformatf("b2b rdata2 op%0d", k - 2), b2.rdata, bd[(k - 2) / 2]);
            end
            @(posedge clk); #1;
        end
        check("b2b grants", g, 8);
        check("b2b rvalid1 pulses", r1, 8);
        check("b2b rvalid2 pulses", r2, 8);

        // Reset lands while the latency-2 read is still in flight.
        drive(1'b1, 32'h0001_0000, 1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("flight gnt", b1.gnt, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("flush rvalid2", b2.rvalid, 1'b0);
        check("flush rvalid1", b1.rvalid, 1'b0);
        check("flush rdata2", b2.rdata, 32'h0);
        check("flush init_done", done1, 1'b0);
        @(posedge clk); #1;

        init_seq("reinit");
        access(1'b0, 32'h0001_0000, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, "reinit w0");
        access(1'b0, 32'h0001_0004, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, "reinit w1");
        access(1'b0, 32'h0001_003C, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, "reinit w15");

`ifdef RAM_PARITY_EN
        access(1'b1, 32'h0001_0008, 4'hf, 32'h1122_3344, 1'b1, 32'h0, 1'b0, "par wr");
        dut1.u_array.par_mem[2][1] = ~dut1.u_array.par_mem[2][1];
        dut2.u_array.par_mem[2][1] = ~dut2.u_array.par_mem[2][1];
        access(1'b0, 32'h0001_0008, 4'h0, 32'h0, 1'b1, 32'h1122_3344, 1'b1, "par bad");
        access(1'b0, 32'h0001_000C, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, "par ok");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
